// File: rtl/proc_pkg.sv
// Shared processor types: memory-stage FSM states, set-condition encodings
// and ALU flag bit positions within {V, C, N, Z}.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } mem_state_t;

    localparam logic [1:0] SET_SEQ = 2'b00;
    localparam logic [1:0] SET_SLT = 2'b01;
    localparam logic [1:0] SET_SLE = 2'b10;
    localparam logic [1:0] SET_SCO = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    function automatic logic flag_cond(input logic [3:0] flags, input logic [1:0] sel);
        logic lt;
        lt = flags[FLAG_N] ^ flags[FLAG_V];
        case (sel)
            SET_SEQ: flag_cond = flags[FLAG_Z];
            SET_SLT: flag_cond = lt;
            SET_SLE: flag_cond = flags[FLAG_Z] | lt;
            default: flag_cond = flags[FLAG_C];
        endcase
    endfunction

endpackage

// File: rtl/set_cond.sv
// Set-condition evaluation: returns the zero-extended flag condition for set
// ops, otherwise the ALU result unchanged.
module set_cond
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    input  logic [2:0]        set_sel,
    output logic [DATA_W-1:0] value
);

    logic cond;

    always_comb begin
        cond  = flag_cond(alu_flags, set_sel[1:0]);
        value = set_sel[2] ? {{(DATA_W-1){1'b0}}, cond} : alu_result;
    end

endmodule

// File: rtl/stage_memory_mc.sv
// Pipeline memory stage with multi-cycle dmem handshake and MEM/WB register.
// Build option: MEM_ALIGN_CHECK_EN rejects odd-address loads/stores into ERR.
//
// state | meaning
// IDLE  | accepting ops; ALU/set ops retire here, mem ops issue here
// WAIT  | mem request outstanding, counting cycles toward timeout
// HALT  | halt op seen, dump pulsed; frozen until rst
// ERR   | timeout or misaligned access; frozen until rst
module stage_memory_mc
    import proc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [3:0]        alu_flags,
    input  logic [2:0]        set_sel,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_halt,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [REG_W-1:0]  write_reg,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_dump,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] set_value;
    logic [DATA_W-1:0] mem_wb_data;
    logic              mem_wb_we;
    logic              mem_op;
    logic              misalign;
    logic              idle_go;
    logic              issue;
    logic              in_wait;

    set_cond #(.DATA_W(DATA_W)) u_set_cond (
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .set_sel    (set_sel),
        .value      (set_value)
    );

    always_comb begin
        mem_op = mem_read | mem_write;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = alu_result[0];
`else
        misalign = 1'b0;
`endif
        // Request lines are gated by rst so they read 0 throughout reset.
        idle_go = !rst && (state == IDLE) && in_valid;
        issue   = idle_go && mem_op && !misalign;
        in_wait = !rst && (state == WAIT);

        dmem_req   = issue | in_wait;
        dmem_we    = dmem_req & mem_write;
        dmem_addr  = dmem_req ? alu_result : '0;
        dmem_wdata = dmem_req ? store_data : '0;
        dmem_dump  = idle_go & mem_halt;

        stall = ((issue | in_wait) & ~dmem_ack)
              | (idle_go & mem_op & misalign)
              | (idle_go & mem_halt)
              | (state == HALT) | (state == ERR);

        mem_wb_data = mem_to_reg ? dmem_rdata : set_value;
        mem_wb_we   = reg_write & ~mem_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            halted       <= 1'b0;
            err          <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mem_halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (mem_op) begin
                            if (misalign) begin
                                state <= ERR;
                                err   <= 1'b1;
                            end else if (dmem_ack) begin
                                wb_valid     <= 1'b1;
                                wb_reg_write <= mem_wb_we;
                                wb_reg       <= write_reg;
                                wb_data      <= mem_wb_data;
                            end else begin
                                state <= WAIT;
                                cnt   <= '0;
                            end
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= reg_write;
                            wb_reg       <= write_reg;
                            wb_data      <= set_value;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state        <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= mem_wb_we;
                        wb_reg       <= write_reg;
                        wb_data      <= mem_wb_data;
                    end else if (cnt == CNT_LAST) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HALT: state <= HALT;
                ERR:  state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
